// File: rtl/gpio_cfg_pkg.sv
// Shared GPIO pad config layout, reset value, settle counter width and sequencer states.
// Definitions only: no latency, no backpressure.
package gpio_cfg_pkg;
    localparam int CFG_W           = 11;
    localparam int DM_LSB          = 0;
    localparam int INP_DIS_BIT     = 3;
    localparam int IB_MODE_SEL_BIT = 4;
    localparam int VTRIP_SEL_BIT   = 5;
    localparam int SLOW_SEL_BIT    = 6;
    localparam int HOLDOVER_BIT    = 7;
    localparam int ANALOG_EN_BIT   = 8;
    localparam int ANALOG_SEL_BIT  = 9;
    localparam int ANALOG_POL_BIT  = 10;

    localparam logic [CFG_W-1:0] RST_CFG = 11'h001;
    localparam int               CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISO_WAIT = 2'd1,
        ST_SETTLE   = 2'd2
    } state_t;
endpackage

// File: rtl/gpio_cfg_settle_timer.sv
// Loadable down-counter with zero flag; a load lands one edge later, zero is combinational.
// Holds at zero, so it can never wrap; no backpressure.
module gpio_cfg_settle_timer
    import gpio_cfg_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/gpio_pad_cfg_seq.sv
// Per-pad config store that isolates a pad, writes its config and settles before release.
// Write takes 2*SETTLE_CYCLES edges; cmd_ready is low while busy, the requester holds cmd_valid.
module gpio_pad_cfg_seq
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS      = 44,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [5:0]          cmd_pad,
    input  logic [CFG_W-1:0]    cmd_cfg,
    output logic                done,
    output logic                err,
    output logic                busy,
    input  logic [5:0]          rd_pad,
    output logic [CFG_W-1:0]    rd_cfg,
    input  logic [NUM_PADS-1:0] user_oeb,
    output logic [NUM_PADS-1:0] gpio_oeb,
    output logic [NUM_PADS-1:0] gpio_dm2,
    output logic [NUM_PADS-1:0] gpio_dm1,
    output logic [NUM_PADS-1:0] gpio_dm0,
    output logic [NUM_PADS-1:0] gpio_inp_dis,
    output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
    output logic [NUM_PADS-1:0] gpio_vtrip_sel,
    output logic [NUM_PADS-1:0] gpio_slow_sel,
    output logic [NUM_PADS-1:0] gpio_holdover,
    output logic [NUM_PADS-1:0] gpio_analog_en,
    output logic [NUM_PADS-1:0] gpio_analog_sel,
    output logic [NUM_PADS-1:0] gpio_analog_pol
);
    localparam logic [6:0]       NUM_PADS_W    = 7'(NUM_PADS);
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CFG_W-1:0]     r_cfg [NUM_PADS];
    logic [NUM_PADS-1:0]  r_iso_mask;
    logic [5:0]           r_pad;
    logic [CFG_W-1:0]     r_new_cfg;
    logic                 r_done;
    logic                 r_err;
    logic [CFG_W-1:0]     r_rd_cfg;

    logic                 w_pad_ok;
    logic                 w_rd_ok;
    logic                 w_same_cfg;
    logic [NUM_PADS-1:0]  w_iso_onehot;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_cfg_wr;
    logic                 w_iso_clr;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_tmr_load;
    logic                 w_tmr_dec;
    logic                 w_tmr_zero;

    assign w_pad_ok     = ({1'b0, cmd_pad} < NUM_PADS_W);
    assign w_rd_ok      = ({1'b0, rd_pad} < NUM_PADS_W);
    assign w_same_cfg   = w_pad_ok && (r_cfg[cmd_pad] == cmd_cfg);
    assign w_iso_onehot = NUM_PADS'(1) << cmd_pad;

    gpio_cfg_settle_timer u_timer (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .i_load     (w_tmr_load),
        .i_load_val (SETTLE_RELOAD),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        w_cfg_wr    = 1'b0;
        w_iso_clr   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (!w_pad_ok) begin
                        w_err_nxt = 1'b1;
                    end else if (w_same_cfg) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_start     = 1'b1;
                        w_tmr_load  = 1'b1;
                        w_state_nxt = ST_ISO_WAIT;
                    end
                end
            end
            ST_ISO_WAIT: begin
                if (w_tmr_zero) begin
                    w_cfg_wr    = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_zero) begin
                    w_iso_clr   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmr_dec = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < NUM_PADS; i++) r_cfg[i] <= RST_CFG;
            r_iso_mask <= '0;
            r_pad      <= '0;
            r_new_cfg  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_cfg   <= '0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if (w_accept) begin
                r_pad     <= cmd_pad;
                r_new_cfg <= cmd_cfg;
            end
            // Only one pad is ever in flight, so release clears the whole mask.
            if (w_start)        r_iso_mask <= w_iso_onehot;
            else if (w_iso_clr) r_iso_mask <= '0;
            if (w_cfg_wr) r_cfg[r_pad] <= r_new_cfg;
            r_rd_cfg <= w_rd_ok ? r_cfg[rd_pad] : '0;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign rd_cfg    = r_rd_cfg;
    assign gpio_oeb  = user_oeb | r_iso_mask;

    for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
        assign gpio_dm0[gi]         = r_cfg[gi][DM_LSB];
        assign gpio_dm1[gi]         = r_cfg[gi][DM_LSB+1];
        assign gpio_dm2[gi]         = r_cfg[gi][DM_LSB+2];
        assign gpio_inp_dis[gi]     = r_cfg[gi][INP_DIS_BIT];
        assign gpio_ib_mode_sel[gi] = r_cfg[gi][IB_MODE_SEL_BIT];
        assign gpio_vtrip_sel[gi]   = r_cfg[gi][VTRIP_SEL_BIT];
        assign gpio_slow_sel[gi]    = r_cfg[gi][SLOW_SEL_BIT];
        assign gpio_holdover[gi]    = r_cfg[gi][HOLDOVER_BIT];
        assign gpio_analog_en[gi]   = r_cfg[gi][ANALOG_EN_BIT];
        assign gpio_analog_sel[gi]  = r_cfg[gi][ANALOG_SEL_BIT];
        assign gpio_analog_pol[gi]  = r_cfg[gi][ANALOG_POL_BIT];
    end
endmodule

// File: tb/tb_gpio_pad_cfg_seq.sv
// Bench for gpio_pad_cfg_seq: directed scenarios then random commands against a transaction-level model.
module tb_gpio_pad_cfg_seq;
    localparam int NP = 44;
    localparam int S  = 4;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [5:0]    cmd_pad;
    logic [10:0]   cmd_cfg;
    logic          done, err, busy;
    logic [5:0]    rd_pad;
    logic [10:0]   rd_cfg;
    logic [NP-1:0] user_oeb, gpio_oeb;
    logic [NP-1:0] gpio_dm2, gpio_dm1, gpio_dm0, gpio_inp_dis, gpio_ib_mode_sel;
    logic [NP-1:0] gpio_vtrip_sel, gpio_slow_sel, gpio_holdover;
    logic [NP-1:0] gpio_analog_en, gpio_analog_sel, gpio_analog_pol;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [10:0] model_cfg [NP];
    logic [10:0] rd_exp;
    bit          rd_exp_vld = 0;
    bit          rd_fixed   = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    gpio_pad_cfg_seq #(.NUM_PADS(NP), .SETTLE_CYCLES(S)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pad(cmd_pad), .cmd_cfg(cmd_cfg),
        .done(done), .err(err), .busy(busy), .rd_pad(rd_pad), .rd_cfg(rd_cfg),
        .user_oeb(user_oeb), .gpio_oeb(gpio_oeb),
        .gpio_dm2(gpio_dm2), .gpio_dm1(gpio_dm1), .gpio_dm0(gpio_dm0),
        .gpio_inp_dis(gpio_inp_dis), .gpio_ib_mode_sel(gpio_ib_mode_sel),
        .gpio_vtrip_sel(gpio_vtrip_sel), .gpio_slow_sel(gpio_slow_sel),
        .gpio_holdover(gpio_holdover), .gpio_analog_en(gpio_analog_en),
        .gpio_analog_sel(gpio_analog_sel), .gpio_analog_pol(gpio_analog_pol)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] pad_cfg(input int i);
        return {gpio_analog_pol[i], gpio_analog_sel[i], gpio_analog_en[i], gpio_holdover[i],
                gpio_slow_sel[i], gpio_vtrip_sel[i], gpio_ib_mode_sel[i], gpio_inp_dis[i],
                gpio_dm2[i], gpio_dm1[i], gpio_dm0[i]};
    endfunction

    function automatic logic [10:0] model_rd(input logic [5:0] p);
        return (int'(p) < NP) ? model_cfg[int'(p)] : 11'h000;
    endfunction

    task automatic set_rd(input logic [5:0] p);
        rd_pad = p;
        rd_exp = model_rd(p);
    endtask

    // One clock: edge, readback check, model update for that edge, fresh random inputs.
    task automatic cycle(input int upd_pad, input logic [10:0] upd_cfg);
        bit rst_now;
        rst_now = wb_rst_i;
        @(posedge wb_clk_i);
        #1;
        if (rst_now) begin
            for (int i = 0; i < NP; i++) model_cfg[i] = 11'h001;
            chk("rd_cfg_rst", 64'(rd_cfg), 64'(11'h000));
        end else if (rd_exp_vld) begin
            chk("rd_cfg", 64'(rd_cfg), 64'(rd_exp));
        end
        if (!rst_now && upd_pad >= 0) model_cfg[upd_pad] = upd_cfg;
        user_oeb = NP'({$urandom(), $urandom()});
        if (!rd_fixed) rd_pad = 6'($urandom_range(0, 63));
        rd_exp     = model_rd(rd_pad);
        rd_exp_vld = 1;
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NP; i++) chk(tag, 64'(pad_cfg(i)), 64'(model_cfg[i]));
    endtask

    task automatic idle_cycle();
        cycle(-1, 11'h0);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_done", 64'(done), 64'(0));
        chk("idle_err", 64'(err), 64'(0));
        chk("idle_oeb", 64'(gpio_oeb), 64'(user_oeb));
    endtask

    task automatic do_cmd(input int pad, input logic [10:0] cfg, input bit hold);
        int            guard;
        bit            inval, same;
        logic [10:0]   old;
        logic [NP-1:0] bitm;
        cmd_valid = 1'b1;
        cmd_pad   = 6'(pad);
        cmd_cfg   = cfg;
        guard     = 0;
        while (cmd_ready !== 1'b1 && guard < 40) begin
            cycle(-1, 11'h0);
            guard++;
        end
        chk("ready_wait", 64'(cmd_ready), 64'(1));
        inval = (pad >= NP);
        old   = inval ? 11'h000 : model_cfg[pad];
        same  = !inval && (old == cfg);
        cycle(-1, 11'h0);
        if (!hold || inval || same) cmd_valid = 1'b0;
        if (inval) begin
            chk("err_pulse", 64'(err), 64'(1));
            chk("err_no_done", 64'(done), 64'(0));
            chk("err_ready", 64'(cmd_ready), 64'(1));
            chk("err_oeb", 64'(gpio_oeb), 64'(user_oeb));
            cycle(-1, 11'h0);
            chk("err_clear", 64'(err), 64'(0));
            chk("err_no_done2", 64'(done), 64'(0));
        end else if (same) begin
            chk("same_done", 64'(done), 64'(1));
            chk("same_err", 64'(err), 64'(0));
            chk("same_busy", 64'(busy), 64'(0));
            chk("same_oeb", 64'(gpio_oeb), 64'(user_oeb));
            cycle(-1, 11'h0);
            chk("same_done_clr", 64'(done), 64'(0));
            chk("same_oeb2", 64'(gpio_oeb), 64'(user_oeb));
        end else begin
            bitm      = '0;
            bitm[pad] = 1'b1;
            for (int k = 0; k <= 2 * S; k++) begin
                if (k > 0) cycle((k == S) ? pad : -1, cfg);
                chk("iso_oeb", 64'(gpio_oeb), 64'(user_oeb | ((k < 2 * S) ? bitm : '0)));
                chk("busy", 64'(busy), 64'(k < 2 * S));
                chk("ready", 64'(cmd_ready), 64'(k >= 2 * S));
                chk("done", 64'(done), 64'(k == 2 * S));
                chk("no_err", 64'(err), 64'(0));
                chk("pad_cfg", 64'(pad_cfg(pad)), 64'((k >= S) ? cfg : old));
            end
        end
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_pad   = '0;
        cmd_cfg   = '0;
        rd_pad    = '0;
        user_oeb  = '0;
        for (int i = 0; i < NP; i++) model_cfg[i] = 11'h001;

        cycle(-1, 11'h0);
        cycle(-1, 11'h0);
        wb_rst_i = 1'b0;
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_oeb", 64'(gpio_oeb), 64'(user_oeb));
        check_all("rst_cfg");
        rd_fixed = 1;
        set_rd(6'd0);
        cycle(-1, 11'h0);
        chk("rd_pad0", 64'(rd_cfg), 64'(11'h001));
        set_rd(6'd50);
        cycle(-1, 11'h0);
        chk("rd_oob", 64'(rd_cfg), 64'(0));
        rd_fixed = 0;

        do_cmd(5, 11'h006, 0);
        chk("dm5", 64'({gpio_dm2[5], gpio_dm1[5], gpio_dm0[5]}), 64'(3'b110));
        do_cmd(44, 11'h7FF, 0);
        check_all("err_cfg");
        do_cmd(3, 11'h001, 0);
        do_cmd(1, 11'h0A5, 1);
        do_cmd(2, 11'h35A, 0);
        idle_cycle();

        // Reset lands on edge 6 of a pad 7 write, after the config was already stored.
        cmd_valid = 1'b1;
        cmd_pad   = 6'd7;
        cmd_cfg   = 11'h155;
        cycle(-1, 11'h0);
        cmd_valid = 1'b0;
        chk("r7_iso", 64'(gpio_oeb[7]), 64'(1));
        for (int k = 1; k <= 5; k++) cycle((k == S) ? 7 : -1, 11'h155);
        chk("r7_cfg_new", 64'(pad_cfg(7)), 64'(11'h155));
        wb_rst_i = 1'b1;
        cycle(-1, 11'h0);
        wb_rst_i = 1'b0;
        chk("r7_cfg", 64'(pad_cfg(7)), 64'(11'h001));
        chk("r7_oeb", 64'(gpio_oeb), 64'(user_oeb));
        chk("r7_ready", 64'(cmd_ready), 64'(1));
        chk("r7_busy", 64'(busy), 64'(0));
        idle_cycle();
        idle_cycle();
        check_all("r7_all");

        for (int n = 0; n < 30; n++) begin
            int          p;
            logic [10:0] c;
            p = $urandom_range(0, 49);
            if (p < NP && $urandom_range(0, 3) == 0) c = model_cfg[p];
            else c = 11'($urandom());
            do_cmd(p, c, bit'($urandom_range(0, 1)));
            if (!cmd_valid) begin
                int idle_n;
                idle_n = $urandom_range(0, 2);
                for (int j = 0; j < idle_n; j++) idle_cycle();
            end
        end
        cmd_valid = 1'b0;
        idle_cycle();
        idle_cycle();
        check_all("final_cfg");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gpio_pad_cfg_seq.md
GPIO_PAD_CFG_SEQ -- requirements
Module: gpio_pad_cfg_seq

Interface
REQ-001 Parameter NUM_PADS, default 44, number of controlled pads (equals OPENFRAME_IO_PADS).
REQ-002 Parameter SETTLE_CYCLES, default 4, isolation/settle interval in clocks; legal range 1..255.
REQ-003 The block SHALL use one clock, wb_clk_i; reset is wb_rst_i, synchronous and active-high.
REQ-004 wb_clk_i  in  1  sole clock.
REQ-005 wb_rst_i  in  1  synchronous active-high reset.
REQ-006 cmd_valid  in  1  config write request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_pad  in  6  target pad index.
REQ-009 cmd_cfg  in  11  new pad config word: [2:0] dm, [3] inp_dis, [4] ib_mode_sel, [5] vtrip_sel, [6] slow_sel, [7] holdover, [8] analog_en, [9] analog_sel, [10] analog_pol.
REQ-010 done  out  1  one-cycle pulse when a command completes.
REQ-011 err  out  1  one-cycle pulse when a command targets pad index >= NUM_PADS.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 rd_pad  in  6  readback pad index.
REQ-014 rd_cfg  out  11  registered config of rd_pad.
REQ-015 user_oeb  in  NUM_PADS  output enables from user logic, active-low.
REQ-016 gpio_oeb  out  NUM_PADS  pad output enables, active-low.
REQ-017 gpio_dm2, gpio_dm1, gpio_dm0, gpio_inp_dis, gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_holdover, gpio_analog_en, gpio_analog_sel, gpio_analog_pol  out  NUM_PADS each  registered per-pad fields of the stored config.

Function
REQ-018 The block SHALL hold one 11-bit config register per pad; every gpio_* config output bit SHALL be driven directly from that register.
REQ-019 gpio_oeb[i] SHALL equal user_oeb[i] OR iso_mask[i]; this path is combinational.
REQ-020 The FSM SHALL have states IDLE, ISO_WAIT and SETTLE; cmd_ready SHALL equal (state == IDLE) and SHALL NOT depend combinationally on cmd_valid.
REQ-021 A command is accepted on a clock edge where cmd_valid and cmd_ready are both high; cmd_pad and cmd_cfg SHALL be captured on that edge.
REQ-022 On accepting a command with an invalid pad (index >= NUM_PADS), the block SHALL remain in IDLE, leave all registers unchanged, and pulse err in the next cycle with no done pulse.
REQ-023 On accepting a command whose cmd_cfg equals the stored config, the block SHALL remain in IDLE, leave iso_mask unchanged, and pulse done in the next cycle.
REQ-024 Otherwise, on the accept edge, the block SHALL set iso_mask[pad], load the counter with SETTLE_CYCLES-1, and enter ISO_WAIT.
REQ-025 In ISO_WAIT the counter SHALL decrement each cycle; on the edge where it is 0, the block SHALL write cmd_cfg into the pad register, reload the counter with SETTLE_CYCLES-1, and enter SETTLE.
REQ-026 In SETTLE the counter SHALL decrement each cycle; on the edge where it is 0, the block SHALL clear iso_mask[pad], pulse done in the next cycle, and enter IDLE.
REQ-027 Resulting timing for an accept at edge T: config visible after edge T+SETTLE_CYCLES; isolation released and done high after edge T+2*SETTLE_CYCLES; next accept possible at that same edge.
REQ-028 While busy, cmd_valid SHALL be ignored; commands are never queued or dropped silently, because the requester holds cmd_valid.
REQ-029 At most one iso_mask bit SHALL be set at any time.
REQ-030 rd_cfg SHALL update one cycle after rd_pad; it SHALL read 0 for an out-of-range rd_pad and SHALL reflect a write one cycle after the write edge.
REQ-031 The counter width SHALL be 8 bits; counter wrap-around SHALL be unreachable by construction.

Reset
REQ-032 When reset is asserted, every pad config SHALL be set to 11'h001 (dm=001, all other fields 0).
REQ-033 When reset is asserted, iso_mask SHALL be 0, state SHALL be IDLE, counter SHALL be 0, done, err and rd_cfg SHALL be 0, and cmd_ready SHALL be 1 in the first cycle after reset.
REQ-034 Reset asserted mid-sequence SHALL abort the command, including an in-progress pad write, and apply the values in REQ-032..033 on the next edge.

Structure
REQ-035 Package gpio_cfg_pkg SHALL hold: config width (11), field bit offsets, the reset config 11'h001, and the FSM state enum.
REQ-036 Sub-module gpio_cfg_settle_timer SHALL implement the load/decrement/zero-flag counter; all other logic stays in the top module.

Verification (SETTLE_CYCLES=4)
REQ-037 Release reset -> all dm=001, gpio_oeb == user_oeb, cmd_ready=1, rd_cfg(pad 0)=0x001.
REQ-038 Write pad 5 cfg=0x006 accepted at edge 0 -> gpio_oeb[5]=1 after edge 0; dm[5]=110 after edge 4; gpio_oeb[5] returns to user_oeb[5] and done=1 after edge 8.
REQ-039 Write pad 44 -> err pulse after one cycle, no done pulse, no output change, cmd_ready stays 1.
REQ-040 Write pad 3 with its current cfg 0x001 -> done pulse after one cycle, iso_mask never set.
REQ-041 Hold cmd_valid across two back-to-back writes (pad 1, then pad 2) -> second accepted at the edge after done of the first; only one iso bit set at any time.
REQ-042 Assert reset at edge 6 of a pad 7 write -> pad 7 cfg=0x001, gpio_oeb[7]=user_oeb[7], state IDLE.
